// File: rtl/lsu_datamem.sv
// rtl/lsu_datamem.sv - RV32I load/store unit in front of a word-organised data memory.
// One outstanding request: IDLE accepts, ACCESS waits 1+WAIT_STATES cycles, RESP strobes the result.
module lsu_datamem #(
  parameter int DM_ADDRESS  = 9,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int         DEPTH    = 2 ** (DM_ADDRESS - 2);
  localparam logic [3:0] LAST_CNT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q;
  logic [2:0]              f3_q;
  logic [DM_ADDRESS-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [31:0]             mem [DEPTH];

  logic                    accept;
  logic                    leave_access;
  logic                    illegal, misaligned, bad;
  logic [DM_ADDRESS-3:0]   word_idx;
  logic [1:0]              off;
  logic [31:0]             word_rd;
  logic [7:0]              byte_v;
  logic [15:0]             half_v;
  logic [31:0]             load_val;
  logic [3:0]              be;
  logic [31:0]             wr_data;
  logic                    write_en;

  assign req_ready    = (state_q == IDLE) && !reset;
  assign accept       = req_valid && req_ready;
  assign leave_access = (state_q == ACCESS) && (cnt_q == LAST_CNT);

  assign rsp_valid = (state_q == RESP) && !reset;
  assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
  assign rsp_err   = rsp_valid && err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ACCESS;
          cnt_d   = 4'd0;
        end
      end
      ACCESS: begin
        if (leave_access) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign word_idx = addr_q[DM_ADDRESS-1:2];
  assign off      = addr_q[1:0];

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (we_q) begin
      illegal = !(f3_q inside {3'b000, 3'b001, 3'b010});
    end else begin
      illegal = f3_q inside {3'b011, 3'b110, 3'b111};
    end
    case (f3_q[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  assign bad = illegal || misaligned;

  assign word_rd = mem[word_idx];
  assign byte_v  = word_rd[{off, 3'b000} +: 8];
  assign half_v  = word_rd[{off[1], 4'b0000} +: 16];

  always_comb begin
    load_val = 32'd0;
    case (f3_q)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b010:  load_val = word_rd;
      3'b100:  load_val = {24'd0, byte_v};
      3'b101:  load_val = {16'd0, half_v};
      default: load_val = 32'd0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    be      = 4'b0000;
    wr_data = 32'd0;
    case (f3_q[1:0])
      2'b00: begin
        be      = 4'b0001 << off;
        wr_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be      = 4'b0011 << {off[1], 1'b0};
        wr_data = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        be      = 4'b1111;
        wr_data = wdata_q;
      end
      default: begin
        be      = 4'b0000;
        wr_data = 32'd0;
      end
    endcase
  end

  assign write_en = leave_access && we_q && !bad && !reset;

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (leave_access) begin
      rdata_d = (we_q || bad) ? 32'd0 : load_val;
      err_d   = bad;
    end else if (state_q == RESP) begin
      rdata_d = 32'd0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Array contents survive reset; only the write enable is gated by it.
  always_ff @(posedge clk) begin
    if (write_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_lsu_datamem.sv
// tb/tb_lsu_datamem.sv - Directed bench for lsu_datamem with WAIT_STATES=0 and WAIT_STATES=3 instances.
module tb_lsu_datamem;
  localparam int AW  = 9;
  localparam int WS0 = 0;
  localparam int WS1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        rv  [2];
  logic        rr  [2];
  logic        rwe [2];
  logic [2:0]  rf3 [2];
  logic [AW-1:0] ra [2];
  logic [31:0] rwd [2];
  logic        sv  [2];
  logic [31:0] srd [2];
  logic        se  [2];

  int ws_of [2] = '{WS0, WS1};
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  lsu_datamem #(.DM_ADDRESS(AW), .WAIT_STATES(WS0)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(rr[0]), .req_we(rwe[0]),
    .req_funct3(rf3[0]), .req_addr(ra[0]), .req_wdata(rwd[0]), .rsp_valid(sv[0]),
    .rsp_rdata(srd[0]), .rsp_err(se[0]));

  lsu_datamem #(.DM_ADDRESS(AW), .WAIT_STATES(WS1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(rr[1]), .req_we(rwe[1]),
    .req_funct3(rf3[1]), .req_addr(ra[1]), .req_wdata(rwd[1]), .rsp_valid(sv[1]),
    .rsp_rdata(srd[1]), .rsp_err(se[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: byte-level memory image plus the transaction it is working on.
  logic [31:0] mmem [2][128];
  bit          m_busy [2];
  bit          m_acc_now [2];
  int          m_acc [2];
  bit          p_we [2];
  logic [2:0]  p_f3 [2];
  logic [8:0]  p_a [2];
  logic [31:0] p_wd [2];
  logic [31:0] m_rd [2];
  bit          m_err [2];

  function automatic void model_exec(input int d, output logic [31:0] rd, output bit err);
    int idx, off, size, src;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    bit legal, mis;
    idx  = int'(p_a[d]) / 4;
    off  = int'(p_a[d]) % 4;
    size = int'(p_f3[d]) % 4;
    w    = mmem[d][idx];
    b    = 8'(w >> (8 * off));
    h    = 16'(w >> (16 * (off / 2)));
    rd   = 32'd0;
    if (p_we[d]) legal = (p_f3[d] <= 3'd2);
    else         legal = !(p_f3[d] == 3'd3 || p_f3[d] >= 3'd6);
    mis = (size == 1 && (off % 2) != 0) || (size == 2 && off != 0);
    err = !legal || mis;
    if (err) return;
    if (p_we[d]) begin
      for (int k = 0; k < 4; k++) begin
        if (size == 2 || (size == 1 && k / 2 == off / 2) || (size == 0 && k == off)) begin
          src = (size == 0) ? 0 : (size == 1) ? (k % 2) : k;
          w[8*k +: 8] = 8'(p_wd[d] >> (8 * src));
        end
      end
      mmem[d][idx] = w;
    end else begin
      case (p_f3[d])
        3'd0: rd = {{24{b[7]}}, b};
        3'd1: rd = {{16{h[15]}}, h};
        3'd2: rd = w;
        3'd4: rd = {24'd0, b};
        3'd5: rd = {16'd0, h};
        default: rd = 32'd0;
      endcase
    end
  endfunction

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      m_acc_now[d] = 1'b0;
      if (reset) begin
        m_busy[d] = 1'b0;
      end else if (!m_busy[d]) begin
        if (rv[d]) begin
          m_busy[d] = 1'b1; m_acc[d] = cyc; m_acc_now[d] = 1'b1;
          p_we[d] = rwe[d]; p_f3[d] = rf3[d]; p_a[d] = ra[d]; p_wd[d] = rwd[d];
        end
      end else if (cyc == m_acc[d] + 1 + ws_of[d]) begin
        model_exec(d, m_rd[d], m_err[d]);
      end else if (cyc == m_acc[d] + 2 + ws_of[d]) begin
        m_busy[d] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      bit ev, er;
      ev = !reset && m_busy[d] && (cyc == m_acc[d] + 1 + ws_of[d]);
      er = !reset && !m_busy[d];
      chk($sformatf("req_ready[%0d]@%0d", d, cyc), 32'(rr[d]), 32'(er));
      chk($sformatf("rsp_valid[%0d]@%0d", d, cyc), 32'(sv[d]), 32'(ev));
      chk($sformatf("rsp_rdata[%0d]@%0d", d, cyc), srd[d], ev ? m_rd[d] : 32'd0);
      chk($sformatf("rsp_err[%0d]@%0d", d, cyc), 32'(se[d]), ev ? 32'(m_err[d]) : 32'd0);
    end
  end

  task automatic do_req(input int d, input bit we, input logic [2:0] f3, input logic [8:0] a,
                        input logic [31:0] wd, input bit keep,
                        output logic [31:0] got_rd, output bit got_err, output int acc_cyc);
    int n;
    got_rd = 32'hBAAD_BAAD; got_err = 1'b1; acc_cyc = -1;
    rwe[d] = we; rf3[d] = f3; ra[d] = a; rwd[d] = wd; rv[d] = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!m_acc_now[d] && n < 40);
    if (!m_acc_now[d]) begin
      chk($sformatf("accept_timeout[%0d]", d), 32'd0, 32'd1);
      rv[d] = 1'b0;
      return;
    end
    acc_cyc = m_acc[d];
    if (keep) return;
    rv[d] = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (sv[d]) begin
        got_rd = srd[d]; got_err = se[d];
        chk($sformatf("rsp_latency[%0d]", d), 32'(cyc - acc_cyc), 32'(1 + ws_of[d]));
        break;
      end
      n++;
    end
    if (n >= 40) chk($sformatf("rsp_timeout[%0d]", d), 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic ld(input int d, input logic [2:0] f3, input logic [8:0] a,
                    input logic [31:0] exp, input bit eerr, input string nm);
    logic [31:0] rd; bit er; int ac;
    do_req(d, 1'b0, f3, a, 32'd0, 1'b0, rd, er, ac);
    chk({nm, "_rdata"}, rd, exp);
    chk({nm, "_err"}, 32'(er), 32'(eerr));
  endtask

  task automatic st(input int d, input logic [2:0] f3, input logic [8:0] a,
                    input logic [31:0] wd, input bit eerr, input string nm);
    logic [31:0] rd; bit er; int ac;
    do_req(d, 1'b1, f3, a, wd, 1'b0, rd, er, ac);
    chk({nm, "_rdata"}, rd, 32'd0);
    chk({nm, "_err"}, 32'(er), 32'(eerr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd; bit er;
    int acc [3];
    int seen;
    for (int d = 0; d < 2; d++) begin
      rv[d] = 1'b0; rwe[d] = 1'b0; rf3[d] = 3'd0; ra[d] = '0; rwd[d] = 32'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready0", 32'(rr[0]), 32'd0);
    chk("reset_valid0", 32'(sv[0]), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset0", 32'(rr[0]), 32'd1);
    chk("ready_after_reset1", 32'(rr[1]), 32'd1);
    @(posedge clk); #1;

    st(0, 3'b010, 9'h010, 32'h8000_80FF, 1'b0, "sw_010");
    ld(0, 3'b000, 9'h010, 32'hFFFF_FFFF, 1'b0, "lb_010");
    ld(0, 3'b100, 9'h010, 32'h0000_00FF, 1'b0, "lbu_010");
    ld(0, 3'b001, 9'h010, 32'hFFFF_80FF, 1'b0, "lh_010");
    ld(0, 3'b101, 9'h010, 32'h0000_80FF, 1'b0, "lhu_010");
    ld(0, 3'b010, 9'h010, 32'h8000_80FF, 1'b0, "lw_010");

    st(0, 3'b010, 9'h020, 32'h1122_3344, 1'b0, "sw_020");
    st(0, 3'b000, 9'h022, 32'hFFFF_FFAB, 1'b0, "sb_022");
    ld(0, 3'b010, 9'h020, 32'h11AB_3344, 1'b0, "lw_after_sb");
    st(0, 3'b001, 9'h022, 32'h5555_BEEF, 1'b0, "sh_022");
    ld(0, 3'b010, 9'h020, 32'hBEEF_3344, 1'b0, "lw_after_sh");
    ld(0, 3'b000, 9'h023, 32'hFFFF_FFBE, 1'b0, "lb_023");
    ld(0, 3'b101, 9'h022, 32'h0000_BEEF, 1'b0, "lhu_022");

    ld(0, 3'b010, 9'h021, 32'd0, 1'b1, "lw_mis_021");
    st(0, 3'b001, 9'h023, 32'h0000_1234, 1'b1, "sh_mis_023");
    ld(0, 3'b010, 9'h020, 32'hBEEF_3344, 1'b0, "lw_after_mis");
    ld(0, 3'b011, 9'h020, 32'd0, 1'b1, "ld_f3_011");
    st(0, 3'b100, 9'h020, 32'h0000_0000, 1'b1, "st_f3_100");
    ld(0, 3'b010, 9'h020, 32'hBEEF_3344, 1'b0, "lw_after_ill");

    st(0, 3'b010, 9'h040, 32'h0BAD_F00D, 1'b0, "sw_040_pre");
    do_req(0, 1'b1, 3'b010, 9'h040, 32'hDEAD_BEEF, 1'b1, rd, er, acc[0]);
    reset = 1'b1; rv[0] = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (sv[0]) seen++;
      chk("ready_in_reset", 32'(rr[0]), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_midreset", 32'(rr[0]), 32'd1);
    repeat (4) begin
      @(negedge clk);
      if (sv[0]) seen++;
    end
    chk("no_rsp_after_abort", 32'(seen), 32'd0);
    @(posedge clk); #1;
    ld(0, 3'b010, 9'h040, 32'h0BAD_F00D, 1'b0, "lw_040_abort");

    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 3; k++)
        do_req(d, 1'b1, 3'b010, 9'(9'h080 + 4 * k), 32'hA5A5_0000 + 32'(k), 1'b1, rd, er, acc[k]);
      chk($sformatf("b2b_st_period01[%0d]", d), 32'(acc[1] - acc[0]), 32'(3 + ws_of[d]));
      chk($sformatf("b2b_st_period12[%0d]", d), 32'(acc[2] - acc[1]), 32'(3 + ws_of[d]));
      for (int k = 0; k < 3; k++)
        do_req(d, 1'b0, 3'b010, 9'(9'h080 + 4 * k), 32'd0, 1'b1, rd, er, acc[k]);
      rv[d] = 1'b0;
      chk($sformatf("b2b_ld_period[%0d]", d), 32'(acc[2] - acc[0]), 32'(2 * (3 + ws_of[d])));
      repeat (8) @(posedge clk);
      #1;
      ld(d, 3'b010, 9'h084, 32'hA5A5_0001, 1'b0, $sformatf("lw_084_%0d", d));
    end

    st(1, 3'b001, 9'h086, 32'h0000_7E57, 1'b0, "sh_086_ws3");
    ld(1, 3'b001, 9'h086, 32'h0000_7E57, 1'b0, "lh_086_ws3");
    ld(1, 3'b010, 9'h085, 32'd0, 1'b1, "lw_mis_ws3");

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
